// File: rtl/fft_mag_peak.sv
// Squared-magnitude post-processor for natural-order FFT bins, with a
// per-frame peak search reporting the first bin holding the largest magnitude.
module fft_mag_peak #(
  parameter int unsigned N_POINTS   = 64,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned SKIP_DC    = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic signed [DATA_WIDTH-1:0]  in_real,
  input  logic signed [DATA_WIDTH-1:0]  in_imag,
  input  logic                          in_valid,
  output logic [2*DATA_WIDTH-1:0]       mag_out,
  output logic [$clog2(N_POINTS)-1:0]   mag_bin,
  output logic                          mag_valid,
  output logic [$clog2(N_POINTS)-1:0]   peak_bin,
  output logic [2*DATA_WIDTH-1:0]       peak_mag,
  output logic                          peak_valid
);

  localparam int unsigned BW = $clog2(N_POINTS);
  localparam int unsigned MW = 2 * DATA_WIDTH;
  localparam logic [BW-1:0] FIRST_BIN = (SKIP_DC != 0) ? BW'(1) : '0;
  localparam logic [BW-1:0] LAST_BIN  = BW'(N_POINTS - 1);

  logic [BW-1:0]        cnt_q, cnt_d;
  logic signed [MW-1:0] re2_q, re2_d, im2_q, im2_d;
  logic [BW-1:0]        bin1_q, bin1_d;
  logic                 v1_q, v1_d;
  logic [MW-1:0]        mag_q, mag_d;
  logic [BW-1:0]        bin2_q, bin2_d;
  logic                 v2_q, v2_d;
  logic [MW-1:0]        run_mag_q, run_mag_d;
  logic [BW-1:0]        run_bin_q, run_bin_d;
  logic [MW-1:0]        peak_mag_q, peak_mag_d;
  logic [BW-1:0]        peak_bin_q, peak_bin_d;
  logic                 peak_valid_q, peak_valid_d;

  logic                 accept;
  logic signed [MW-1:0] re_ext, im_ext;
  logic                 consider, take, last;
  logic [MW-1:0]        cand_mag;
  logic [BW-1:0]        cand_bin;

  always_comb begin
    accept = in_valid && !clear;
    re_ext = {{DATA_WIDTH{in_real[DATA_WIDTH-1]}}, in_real};
    im_ext = {{DATA_WIDTH{in_imag[DATA_WIDTH-1]}}, in_imag};

    cnt_d  = cnt_q;
    if (clear)       cnt_d = '0;
    else if (accept) cnt_d = cnt_q + 1'b1;

    re2_d  = accept ? re_ext * re_ext : re2_q;
    im2_d  = accept ? im_ext * im_ext : im2_q;
    bin1_d = accept ? cnt_q : bin1_q;
    v1_d   = accept;

    mag_d  = $unsigned(re2_q) + $unsigned(im2_q);
    bin2_d = v1_q ? bin1_q : bin2_q;
    v2_d   = v1_q && !clear;

    // Tracker works on the value entering stage 2 so the peak result lands
    // on the same edge as the last bin's magnitude.
    consider = v1_q && !clear && !((SKIP_DC != 0) && (bin1_q == '0));
    take     = (bin1_q == FIRST_BIN) || (mag_d > run_mag_q);
    cand_mag = take ? mag_d  : run_mag_q;
    cand_bin = take ? bin1_q : run_bin_q;
    last     = v1_q && !clear && (bin1_q == LAST_BIN);

    run_mag_d = run_mag_q;
    run_bin_d = run_bin_q;
    if (clear) begin
      run_mag_d = '0;
      run_bin_d = '0;
    end else if (consider) begin
      run_mag_d = cand_mag;
      run_bin_d = cand_bin;
    end

    peak_mag_d   = last ? cand_mag : peak_mag_q;
    peak_bin_d   = last ? cand_bin : peak_bin_q;
    peak_valid_d = last;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      re2_q        <= '0;
      im2_q        <= '0;
      bin1_q       <= '0;
      v1_q         <= 1'b0;
      mag_q        <= '0;
      bin2_q       <= '0;
      v2_q         <= 1'b0;
      run_mag_q    <= '0;
      run_bin_q    <= '0;
      peak_mag_q   <= '0;
      peak_bin_q   <= '0;
      peak_valid_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      re2_q        <= re2_d;
      im2_q        <= im2_d;
      bin1_q       <= bin1_d;
      v1_q         <= v1_d;
      if (v1_q) mag_q <= mag_d;
      bin2_q       <= bin2_d;
      v2_q         <= v2_d;
      run_mag_q    <= run_mag_d;
      run_bin_q    <= run_bin_d;
      peak_mag_q   <= peak_mag_d;
      peak_bin_q   <= peak_bin_d;
      peak_valid_q <= peak_valid_d;
    end
  end

  assign mag_out    = mag_q;
  assign mag_bin    = bin2_q;
  assign mag_valid  = v2_q;
  assign peak_bin   = peak_bin_q;
  assign peak_mag   = peak_mag_q;
  assign peak_valid = peak_valid_q;

endmodule

// File: tb/tb_fft_mag_peak.sv
// Scoreboard bench for fft_mag_peak: two instances (SKIP_DC 0 and 1) share
// one directed stimulus stream; a negedge monitor pops expected results.
module tb_fft_mag_peak;
  localparam int N  = 8;
  localparam int DW = 16;
  localparam int BW = 3;
  localparam int MW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic in_valid = 1'b0;
  logic signed [DW-1:0] in_real = '0;
  logic signed [DW-1:0] in_imag = '0;

  logic [MW-1:0] mag_out, peak_mag, s_mag_out, s_peak_mag;
  logic [BW-1:0] mag_bin, peak_bin, s_mag_bin, s_peak_bin;
  logic          mag_valid, peak_valid, s_mag_valid, s_peak_valid;

  fft_mag_peak #(.N_POINTS(N), .DATA_WIDTH(DW), .SKIP_DC(0)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_real(in_real), .in_imag(in_imag), .in_valid(in_valid),
    .mag_out(mag_out), .mag_bin(mag_bin), .mag_valid(mag_valid),
    .peak_bin(peak_bin), .peak_mag(peak_mag), .peak_valid(peak_valid)
  );

  fft_mag_peak #(.N_POINTS(N), .DATA_WIDTH(DW), .SKIP_DC(1)) dut_skip (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_real(in_real), .in_imag(in_imag), .in_valid(in_valid),
    .mag_out(s_mag_out), .mag_bin(s_mag_bin), .mag_valid(s_mag_valid),
    .peak_bin(s_peak_bin), .peak_mag(s_peak_mag), .peak_valid(s_peak_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [MW-1:0] mag;
    logic [BW-1:0] bin;
    int            due;
  } exp_t;

  exp_t mag_exp[$];
  exp_t pk_exp[$];
  exp_t spk_exp[$];

  int n_cmp = 0;
  int n_bad = 0;
  int exp_bin = 0;
  int fre[N];
  int fim[N];
  int last_pb = 0;
  logic [MW-1:0] last_pm = '0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      if (mag_valid || s_mag_valid) begin
        if (mag_exp.size() == 0) begin
          check("mag_valid_unexpected", 64'(mag_valid | s_mag_valid), 64'd0);
        end else begin
          e = mag_exp.pop_front();
          check("mag_valid",   64'(mag_valid), 64'd1);
          check("s_mag_valid", 64'(s_mag_valid), 64'd1);
          check("mag_out",     64'(mag_out), 64'(e.mag));
          check("s_mag_out",   64'(s_mag_out), 64'(e.mag));
          check("mag_bin",     64'(mag_bin), 64'(e.bin));
          check("mag_latency", 64'(cyc), 64'(e.due));
        end
      end
      if (peak_valid) begin
        if (pk_exp.size() == 0) begin
          check("peak_valid_unexpected", 64'(peak_valid), 64'd0);
        end else begin
          e = pk_exp.pop_front();
          check("peak_bin",     64'(peak_bin), 64'(e.bin));
          check("peak_mag",     64'(peak_mag), 64'(e.mag));
          check("peak_latency", 64'(cyc), 64'(e.due));
        end
      end
      if (s_peak_valid) begin
        if (spk_exp.size() == 0) begin
          check("s_peak_valid_unexpected", 64'(s_peak_valid), 64'd0);
        end else begin
          e = spk_exp.pop_front();
          check("s_peak_bin",     64'(s_peak_bin), 64'(e.bin));
          check("s_peak_mag",     64'(s_peak_mag), 64'(e.mag));
          check("s_peak_latency", 64'(cyc), 64'(e.due));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic send(input int re, input int im);
    exp_t e;
    in_real  = re[DW-1:0];
    in_imag  = im[DW-1:0];
    in_valid = 1'b1;
    e.mag = MW'(re * re + im * im);
    e.bin = exp_bin[BW-1:0];
    e.due = cyc + 2;
    mag_exp.push_back(e);
    tick();
    in_valid = 1'b0;
    exp_bin  = (exp_bin + 1) % N;
  endtask

  task automatic frame(input int pb, input logic [MW-1:0] pm,
                       input int sb, input logic [MW-1:0] sm, input bit gaps);
    exp_t e;
    for (int i = 0; i < N; i++) begin
      if (i == N - 1) begin
        e.due = cyc + 2;
        e.bin = pb[BW-1:0]; e.mag = pm; pk_exp.push_back(e);
        e.bin = sb[BW-1:0]; e.mag = sm; spk_exp.push_back(e);
      end
      send(fre[i], fim[i]);
      if (gaps && i != N - 1) idle(int'($urandom_range(0, 2)));
    end
    last_pb = pb;
    last_pm = pm;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mag_valid"},  64'(mag_valid), 64'd0);
    check({tag, "_mag_out"},    64'(mag_out), 64'd0);
    check({tag, "_mag_bin"},    64'(mag_bin), 64'd0);
    check({tag, "_peak_valid"}, 64'(peak_valid), 64'd0);
    check({tag, "_peak_bin"},   64'(peak_bin), 64'd0);
    check({tag, "_peak_mag"},   64'(peak_mag), 64'd0);
    check({tag, "_s_peak_mag"}, 64'(s_peak_mag), 64'd0);
  endtask

  initial begin
    idle(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    idle(2);

    // Single peak at bin 5 = (3,4)
    fre = '{1, 1, 1, 1, 1, 3, 1, 1}; fim = '{1, 1, 1, 1, 1, 4, 1, 1};
    frame(5, 32'd25, 5, 32'd25, 1'b0);
    // Tie at bins 2 and 6 keeps the lower index
    fre = '{0, 0, 0, 0, 0, 0, 0, 0}; fim = '{0, 0, -7, 0, 0, 0, -7, 0};
    frame(2, 32'd49, 2, 32'd49, 1'b0);
    // Extremes
    fre = '{0, 0, 0, -32768, 0, 0, 32767, 0}; fim = '{0, 0, 0, -32768, 0, 0, 0, 0};
    frame(3, 32'h8000_0000, 3, 32'h8000_0000, 1'b0);
    // DC bin excluded only in the SKIP_DC instance
    fre = '{100, 0, 0, 0, 0, 0, 0, 0}; fim = '{0, 0, 0, 10, 0, 0, 0, 0};
    frame(0, 32'd10000, 3, 32'd100, 1'b0);
    // Back-to-back frames, peaks at 1 then 7
    fre = '{1, 5, 1, 1, 1, 1, 1, 1}; fim = '{0, 5, 0, 0, 0, 0, 0, 0};
    frame(1, 32'd50, 1, 32'd50, 1'b0);
    fre = '{2, 2, 2, 2, 2, 2, 2, -9}; fim = '{2, 2, 2, 2, 2, 2, 2, 2};
    frame(7, 32'd85, 7, 32'd85, 1'b0);
    // Random input gaps; first 17 is at bin 3
    fre = '{3, 0, 2, -4, 1, 0, 4, 1}; fim = '{0, -3, 2, 1, 4, 0, -1, 1};
    frame(3, 32'd17, 3, 32'd17, 1'b1);
    // SKIP_DC: bin 1 loads the tracker unconditionally despite being small
    fre = '{50, 2, 1, 1, 1, 1, 1, 1}; fim = '{0, 0, 0, 0, 0, 0, 0, 0};
    frame(0, 32'd2500, 1, 32'd4, 1'b0);

    // Clear after 4 bins, with a sample presented in the same cycle
    for (int i = 0; i < 4; i++) send(9, 9);
    clear = 1'b1; in_valid = 1'b1; in_real = 16'sd50; in_imag = 16'sd50;
    while (mag_exp.size() > 0 && mag_exp[mag_exp.size() - 1].due > cyc)
      void'(mag_exp.pop_back());
    tick();
    clear = 1'b0; in_valid = 1'b0; exp_bin = 0;
    idle(3);
    check("clear_held_peak_bin", 64'(peak_bin), 64'(last_pb));
    check("clear_held_peak_mag", 64'(peak_mag), 64'(last_pm));
    fre = '{1, 1, 1, 1, 1, 3, 1, 1}; fim = '{1, 1, 1, 1, 1, 4, 1, 1};
    frame(5, 32'd25, 5, 32'd25, 1'b0);
    idle(3);

    // Asynchronous reset mid-frame
    for (int i = 0; i < 3; i++) send(6, 6);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    mag_exp.delete();
    exp_bin = 0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    fre = '{2, 2, 2, 2, 2, 2, 2, -9}; fim = '{2, 2, 2, 2, 2, 2, 2, 2};
    frame(7, 32'd85, 7, 32'd85, 1'b0);

    for (int k = 0; k < 40 && (mag_exp.size() + pk_exp.size() + spk_exp.size()) > 0; k++)
      tick();
    check("pending_mag",    64'(mag_exp.size()), 64'd0);
    check("pending_peak",   64'(pk_exp.size()), 64'd0);
    check("pending_s_peak", 64'(spk_exp.size()), 64'd0);
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
